// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the core/data-memory stall controller.
package riscv_mem_pkg;

    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_stall_state_t;

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/riscv_mem_stall_unit.sv
// Stall/handshake controller between the core and data memory. Issues each
// core request exactly once, stalls the core until the response is ready
// (fixed latency or memory ready), and flags memories that never answer.
module riscv_mem_stall_unit
    import riscv_mem_pkg::*;
#(
    parameter int LATENCY   = 1,
    parameter int USE_READY = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  core_req_i,
    input  logic                  core_we_i,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    input  logic                  mem_ready_i,
    input  logic [MEM_DATA_W-1:0] mem_rdata_i,
    output logic [MEM_DATA_W-1:0] core_rdata_o,
    output logic                  busy_o,
    output logic                  err_o
);

    // One counter serves both the fixed-latency countdown and the watchdog.
    localparam int CNT_MAX = (LATENCY > TIMEOUT) ? LATENCY : TIMEOUT;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT >= 1) ? TIMEOUT - 1 : 0);
    localparam bit RDY_MODE = (USE_READY != 0);
    localparam bit WDOG_EN  = (TIMEOUT != 0);

    if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
        $error("riscv_mem_stall_unit: LATENCY must be in 1..16");
    end
    if (TIMEOUT < 0 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("riscv_mem_stall_unit: TIMEOUT must be in 0..65535");
    end

    mem_stall_state_t      state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [MEM_DATA_W-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  issue;

    // A request is only accepted from IDLE; held requests in DONE belong to
    // the retiring instruction and must not fire a second pulse.
    assign issue = (state_q == IDLE) && core_req_i && !rst_i;

    // State and datapath registers; reset aborts any transaction at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state, counter, captured data and sticky error.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    if (RDY_MODE) begin
                        if (mem_ready_i) begin
                            rdata_d = mem_rdata_i;
                            state_d = DONE;
                        end else begin
                            cnt_d   = '0;
                            state_d = WAIT;
                        end
                    end else if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = LAT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (RDY_MODE) begin
                    if (mem_ready_i) begin
                        rdata_d = mem_rdata_i;
                        state_d = DONE;
                    end else if (WDOG_EN && cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: handshake is combinational from state and the core request.
    always_comb begin
        stall_o      = issue || (state_q == WAIT);
        mem_req_o    = issue;
        mem_we_o     = issue && core_we_i;
        busy_o       = (state_q != IDLE);
        err_o        = err_q;
        core_rdata_o = '0;
        if (state_q == DONE) begin
            // Fixed-latency memory holds its output through DONE.
            core_rdata_o = RDY_MODE ? rdata_q : mem_rdata_i;
        end
    end

endmodule
